monster_direction_sensor: RTL and testbench

//  Generalised successor of the monster collision probe. Samples four probe lines one

---
 rtl/monster_direction_sensor.sv | 145 ++++++++++++++
 tb/tb_monster_direction_sensor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/monster_direction_sensor.sv
// Wall-aware monster direction picker: probes one SPACE outside the sprite on each side,
// latches a per-side blocked mask every frame and selects a held, non-reversing direction.
module monster_direction_sensor #(
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned OBJ_W       = 32,
    parameter int unsigned OBJ_H       = 32,
    parameter int unsigned SPACE       = 2,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [COORD_W-1:0] topLeftX,
    input  logic [COORD_W-1:0] topLeftY,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               wallDrawReq,
    input  logic [1:0]         random_move,
    output logic [1:0]         direction,
    output logic               dirValid,
    output logic               turnPulse,
    output logic [3:0]         blockedMask,
    output logic               anyCollision
);

    localparam int unsigned CW     = COORD_W + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_MOVE,
        S_SEARCH,
        S_STUCK
    } state_t;

    logic [CW-1:0] px, py, tx, ty;
    logic          in_x, in_y;
    logic [3:0]    probe;
    logic [3:0]    hits;
    logic [3:0]    hit_acc;

    state_t            state;
    logic [1:0]        cand;
    logic [1:0]        srch_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        rev;
    logic              cand_ok;

    // Probe lines, evaluated one bit wider than the coordinates so nothing wraps
    always_comb begin
        px   = {1'b0, pixelX};
        py   = {1'b0, pixelY};
        tx   = {1'b0, topLeftX};
        ty   = {1'b0, topLeftY};
        in_x = (px > tx) && (px < tx + CW'(OBJ_W));
        in_y = (py > ty) && (py < ty + CW'(OBJ_H));
        probe[0] = (px == tx + CW'(OBJ_W + SPACE)) && in_y;
        probe[1] = (tx >= CW'(SPACE)) && (px == tx - CW'(SPACE)) && in_y;
        probe[2] = (py == ty + CW'(OBJ_H + SPACE)) && in_x;
        probe[3] = (ty >= CW'(SPACE)) && (py == ty - CW'(SPACE)) && in_x;
        hits     = probe & {4{wallDrawReq}};
    end

    // A hit on the startOfFrame cycle still belongs to the frame being closed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_acc      <= 4'b0000;
            blockedMask  <= 4'b0000;
            anyCollision <= 1'b0;
        end else if (startOfFrame) begin
            hit_acc      <= 4'b0000;
            blockedMask  <= hit_acc | hits;
            anyCollision <= |(hit_acc | hits);
        end else begin
            hit_acc <= hit_acc | hits;
        end
    end

    always_comb begin
        rev     = direction ^ 2'b01;
        cand_ok = !blockedMask[cand] && !(dirValid && (cand == rev));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            direction <= 2'b00;
            dirValid  <= 1'b0;
            turnPulse <= 1'b0;
            cand      <= 2'b00;
            srch_cnt  <= 2'b00;
            hold_cnt  <= '0;
        end else begin
            turnPulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (startOfFrame) state <= S_DECIDE;
                end
                S_MOVE, S_STUCK: begin
                    if (startOfFrame) begin
                        state <= S_DECIDE;
                        if (hold_cnt < HOLD_W'(HOLD_FRAMES)) hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_DECIDE: begin
                    if (dirValid && !blockedMask[direction] && (hold_cnt < HOLD_W'(HOLD_FRAMES))) begin
                        state <= S_MOVE;
                    end else begin
                        cand     <= random_move;
                        srch_cnt <= 2'b00;
                        state    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (startOfFrame) begin
                        state <= S_DECIDE;
                    end else if (cand_ok) begin
                        direction <= cand;
                        dirValid  <= 1'b1;
                        turnPulse <= (cand != direction);
                        hold_cnt  <= '0;
                        state     <= S_MOVE;
                    end else if (srch_cnt == 2'd3) begin
                        // Every forward option rejected: reversing beats standing still
                        if (dirValid && !blockedMask[rev]) begin
                            direction <= rev;
                            turnPulse <= 1'b1;
                            hold_cnt  <= '0;
                            state     <= S_MOVE;
                        end else begin
                            dirValid <= 1'b0;
                            state    <= S_STUCK;
                        end
                    end else begin
                        cand     <= cand + 2'd1;
                        srch_cnt <= srch_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monster_direction_sensor.sv
// Directed bench for monster_direction_sensor: probe geometry, per-frame decision table,
// reverse/stuck corner cases and asynchronous reset in the middle of a search.
module tb_monster_direction_sensor;

    localparam int unsigned COORD_W = 11;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic [COORD_W-1:0] topLeftX = 11'd100;
    logic [COORD_W-1:0] topLeftY = 11'd100;
    logic [COORD_W-1:0] pixelX = 11'd500;
    logic [COORD_W-1:0] pixelY = 11'd500;
    logic               wallDrawReq = 1'b0;
    logic [1:0]         random_move = 2'b00;
    logic [1:0]         direction;
    logic               dirValid;
    logic               turnPulse;
    logic [3:0]         blockedMask;
    logic               anyCollision;

    monster_direction_sensor dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .wallDrawReq  (wallDrawReq),
        .random_move  (random_move),
        .direction    (direction),
        .dirValid     (dirValid),
        .turnPulse    (turnPulse),
        .blockedMask  (blockedMask),
        .anyCollision (anyCollision)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_total = 0;

    always @(posedge clk) if (turnPulse === 1'b1) pulse_total++;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] rnd;
        logic [1:0] dir;
        logic       valid;
        int         pulses;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic park();
        pixelX = 11'd500;
        pixelY = 11'd500;
        wallDrawReq = 1'b0;
    endtask

    task automatic hit_at(input int x, input int y);
        pixelX = COORD_W'(x);
        pixelY = COORD_W'(y);
        wallDrawReq = 1'b1;
        @(negedge clk);
        park();
    endtask

    task automatic do_reset();
        park();
        startOfFrame = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Wall hits for the sprite at (100,100), then SOF; samples 6 clocks after SOF
    task automatic frame(input logic [3:0] mask, input logic [1:0] rnd, output int pulses);
        int base;
        if (mask[0]) hit_at(134, 110);
        if (mask[1]) hit_at(98, 110);
        if (mask[2]) hit_at(110, 134);
        if (mask[3]) hit_at(110, 98);
        random_move = rnd;
        base = pulse_total;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (6) @(negedge clk);
        pulses = pulse_total - base;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p;
        vecs[0]  = '{4'b0000, 2'b10, 2'b10, 1'b1, 1};
        vecs[1]  = '{4'b0000, 2'b01, 2'b10, 1'b1, 0};
        vecs[2]  = '{4'b0000, 2'b11, 2'b10, 1'b1, 0};
        vecs[3]  = '{4'b0000, 2'b00, 2'b10, 1'b1, 0};
        vecs[4]  = '{4'b0000, 2'b00, 2'b00, 1'b1, 1};
        vecs[5]  = '{4'b0000, 2'b01, 2'b00, 1'b1, 0};
        vecs[6]  = '{4'b0000, 2'b01, 2'b00, 1'b1, 0};
        vecs[7]  = '{4'b0000, 2'b01, 2'b00, 1'b1, 0};
        vecs[8]  = '{4'b1110, 2'b11, 2'b00, 1'b1, 0};
        vecs[9]  = '{4'b1101, 2'b10, 2'b01, 1'b1, 1};
        vecs[10] = '{4'b1111, 2'b00, 2'b01, 1'b0, 0};
        vecs[11] = '{4'b0111, 2'b00, 2'b11, 1'b1, 1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_direction", 8'(direction), 8'd0);
        chk("rst_dirValid", 8'(dirValid), 8'd0);
        chk("rst_turnPulse", 8'(turnPulse), 8'd0);
        chk("rst_blockedMask", 8'(blockedMask), 8'd0);
        chk("rst_anyCollision", 8'(anyCollision), 8'd0);
        reset = 1'b0;
        @(negedge clk);

        // Probe geometry: strict bounds around (134,110)
        hit_at(133, 110);
        hit_at(134, 100);
        frame(4'b0000, 2'b00, p);
        chk("near_miss_mask", 8'(blockedMask), 8'd0);
        chk("near_miss_any", 8'(anyCollision), 8'd0);
        hit_at(134, 110);
        frame(4'b0000, 2'b00, p);
        chk("right_hit_mask", 8'(blockedMask), 8'b0001);
        chk("right_hit_any", 8'(anyCollision), 8'd1);

        // Hit on the SOF cycle lands in the closing frame; accumulator then clears
        pixelX = 11'd110;
        pixelY = 11'd134;
        wallDrawReq = 1'b1;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        park();
        chk("same_cycle_mask", 8'(blockedMask), 8'b0100);
        repeat (8) @(negedge clk);
        frame(4'b0000, 2'b00, p);
        chk("cleared_mask", 8'(blockedMask), 8'd0);
        chk("cleared_any", 8'(anyCollision), 8'd0);

        // Per-frame decision table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            frame(vecs[i].mask, vecs[i].rnd, p);
            chk($sformatf("v%0d_direction", i), 8'(direction), 8'(vecs[i].dir));
            chk($sformatf("v%0d_dirValid", i), 8'(dirValid), 8'(vecs[i].valid));
            chk($sformatf("v%0d_blockedMask", i), 8'(blockedMask), 8'(vecs[i].mask));
            chk($sformatf("v%0d_anyCollision", i), 8'(anyCollision), 8'(|vecs[i].mask));
            chk($sformatf("v%0d_turnPulses", i), 8'(p), 8'(vecs[i].pulses));
        end

        // LEFT probe disabled when topLeftX < SPACE
        do_reset();
        topLeftX = 11'd1;
        hit_at(0, 110);
        frame(4'b0000, 2'b00, p);
        chk("left_edge_mask", 8'(blockedMask), 8'd0);
        topLeftX = 11'd100;

        // Asynchronous reset in the middle of a search
        do_reset();
        frame(4'b0000, 2'b11, p);
        chk("pre_direction", 8'(direction), 8'b11);
        hit_at(134, 110);
        hit_at(98, 110);
        hit_at(110, 134);
        hit_at(110, 98);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        chk("pre_mask", 8'(blockedMask), 8'b1111);
        chk("pre_dirValid", 8'(dirValid), 8'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_direction", 8'(direction), 8'd0);
        chk("mid_rst_dirValid", 8'(dirValid), 8'd0);
        chk("mid_rst_turnPulse", 8'(turnPulse), 8'd0);
        chk("mid_rst_blockedMask", 8'(blockedMask), 8'd0);
        chk("mid_rst_anyCollision", 8'(anyCollision), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
